// File: rtl/multicycle_control_fsm_pkg.sv
// multicycle_control_fsm_pkg: shared opcode, ALUOp, mux-select and state constants for the multicycle sequencer
package multicycle_control_fsm_pkg;
    localparam logic [2:0] OP_JUMP   = 3'b000;
    localparam logic [2:0] OP_RTYPE  = 3'b001;
    localparam logic [2:0] OP_LW     = 3'b010;
    localparam logic [2:0] OP_SW     = 3'b011;
    localparam logic [2:0] OP_BRANCH = 3'b100;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFS = 2'b11;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_JUMP   = 4'd2;
    localparam logic [3:0] S_EXEC_R = 4'd3;
    localparam logic [3:0] S_WB_R   = 4'd4;
    localparam logic [3:0] S_ADDR   = 4'd5;
    localparam logic [3:0] S_MEM_RD = 4'd6;
    localparam logic [3:0] S_WB_MEM = 4'd7;
    localparam logic [3:0] S_MEM_WR = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_TRAP   = 4'd10;
endpackage

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: registered fetch/decode/execute/memory/writeback sequencer for the 16-bit multicycle CPU
// Ports: clock/reset_n (async active-low); opcode, zero, mem_ready in;
// pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst,
// reg_write, alu_src_a, alu_src_b, alu_op, illegal_op, state_o out.
// Macro ILLEGAL_TRAP_EN: illegal opcodes lock the FSM in TRAP instead of acting as a NOP.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int OPW = 3,
    parameter int STW = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           pc_write,
    output logic [1:0]     pc_src,
    output logic           ir_write,
    output logic           i_or_d,
    output logic           mem_read,
    output logic           mem_write,
    output logic           mem_to_reg,
    output logic           reg_dst,
    output logic           reg_write,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [1:0]     alu_op,
    output logic           illegal_op,
    output logic [STW-1:0] state_o
);
`ifdef ILLEGAL_TRAP_EN
    localparam logic [3:0] ILLEGAL_NEXT = S_TRAP;
`else
    localparam logic [3:0] ILLEGAL_NEXT = S_FETCH;
`endif

    logic [STW-1:0] r_state;
    logic [STW-1:0] w_next;
    logic           w_pc_write;
    logic           w_ir_write;
    logic           w_mem_write;
    logic           w_reg_write;
    logic           w_illegal;

    assign w_illegal = opcode > OP_BRANCH;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_FETCH;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next      = S_FETCH;
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        pc_src      = PC_ALU;
        i_or_d      = 1'b0;
        mem_read    = 1'b0;
        mem_to_reg  = 1'b0;
        reg_dst     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REG;
        alu_op      = ALU_ADD;
        illegal_op  = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = SRCB_ONE;
                w_ir_write = mem_ready;
                w_pc_write = mem_ready;
                w_next     = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b  = SRCB_BOFS;
                illegal_op = w_illegal;
                w_next     = opcode == OP_JUMP   ? S_JUMP   :
                             opcode == OP_RTYPE  ? S_EXEC_R :
                             opcode == OP_LW || opcode == OP_SW ? S_ADDR :
                             opcode == OP_BRANCH ? S_BRANCH : ILLEGAL_NEXT;
            end
            S_JUMP: begin
                w_pc_write = 1'b1;
                pc_src     = PC_JUMP;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                w_next    = S_WB_R;
            end
            S_WB_R: begin
                reg_dst     = 1'b1;
                w_reg_write = 1'b1;
            end
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                w_next    = opcode == OP_LW ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                w_next   = mem_ready ? S_WB_MEM : S_MEM_RD;
            end
            S_WB_MEM: begin
                w_reg_write = 1'b1;
                mem_to_reg  = 1'b1;
            end
            S_MEM_WR: begin
                w_mem_write = 1'b1;
                i_or_d      = 1'b1;
                w_next      = mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_SUB;
                pc_src     = PC_ALUOUT;
                w_pc_write = zero;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                illegal_op = 1'b1;
                w_next     = S_TRAP;
            end
`endif
            default: w_next = S_FETCH;
        endcase
    end

    // Reset holds the FSM in FETCH, whose write enables follow mem_ready, so gate them explicitly
    assign pc_write  = w_pc_write & reset_n;
    assign ir_write  = w_ir_write & reset_n;
    assign mem_write = w_mem_write & reset_n;
    assign reg_write = w_reg_write & reset_n;
    assign state_o   = r_state;
endmodule
